// File: rtl/ct_ifu_btb_data_array_gen_if.sv
// Access bus between the BTB control pipeline (master) and the BTB data array (slave).
interface ct_ifu_btb_data_array_gen_if #(
  parameter int AW        = 9,
  parameter int BANK_NUM  = 2,
  parameter int SUB_NUM   = 2,
  parameter int SUB_WIDTH = 22
);
  // Handshake: there is no ready. A request (cen_b = 0) is taken in the cycle it is
  // presented only while init_busy = 0 and inv_req = 0; otherwise it is dropped.
  // A taken read returns dout with dout_vld high for exactly the following cycle.
  logic                                   btb_data_cen_b;
  logic                                   btb_data_clk_en;
  logic [BANK_NUM*SUB_NUM-1:0]            btb_data_wen;
  logic [SUB_NUM*SUB_WIDTH-1:0]           btb_data_din;
  logic [AW-1:0]                          btb_index;
  logic                                   btb_data_inv_req;
  logic [BANK_NUM*SUB_NUM*SUB_WIDTH-1:0]  btb_data_dout;
  logic                                   btb_data_dout_vld;
  logic                                   btb_data_init_busy;

  modport master (
    output btb_data_cen_b, btb_data_clk_en, btb_data_wen, btb_data_din,
           btb_index, btb_data_inv_req,
    input  btb_data_dout, btb_data_dout_vld, btb_data_init_busy
  );

  modport slave (
    input  btb_data_cen_b, btb_data_clk_en, btb_data_wen, btb_data_din,
           btb_index, btb_data_inv_req,
    output btb_data_dout, btb_data_dout_vld, btb_data_init_busy
  );
endinterface

// File: rtl/ct_ifu_btb_data_array_gen.sv
// Banked BTB data storage with self-clearing init sweep, registered read strobe and
// output hold. Storage and outputs run on a locally gated clock.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic clk_en_bf_latch;
  logic en_lat;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Enable is captured while the clock is low so the gated clock cannot glitch.
  always_latch begin
    if (!clk_in) en_lat = clk_en_bf_latch | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & en_lat;
endmodule

module ct_ifu_btb_data_array_gen #(
  parameter int DEPTH     = 512,
  parameter int AW        = 9,
  parameter int BANK_NUM  = 2,
  parameter int SUB_NUM   = 2,
  parameter int SUB_WIDTH = 22
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst_b,
  input  logic                           cp0_ifu_icg_en,
  input  logic                           cp0_yy_clk_en,
  input  logic                           pad_yy_icg_scan_en,
  ct_ifu_btb_data_array_gen_if.slave     btb_if,
  output logic                           dbg_state_o
);
  localparam int NW = BANK_NUM * SUB_NUM;
  localparam int DW = NW * SUB_WIDTH;
  localparam logic [AW:0] TERM = (AW+1)'(DEPTH);

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [AW:0]         cnt_inc;
  logic                init_busy;
  logic                access_ok, wr_en, rd_en;
  logic                gated_clk;
  logic [SUB_WIDTH-1:0] mem_q [NW][DEPTH];
  logic [DW-1:0]       rd_data;
  logic [DW-1:0]       dout_q, dout_d;
  logic                vld_q, vld_d;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (btb_if.btb_data_inv_req) begin
          cnt_d = '0;
        end else if (cnt_inc == TERM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (btb_if.btb_data_inv_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign init_busy   = (state_q == INIT);
  assign dbg_state_o = (state_q == IDLE);
  assign access_ok   = !init_busy && !btb_if.btb_data_inv_req && !btb_if.btb_data_cen_b;
  assign wr_en       = access_ok && !(&btb_if.btb_data_wen);
  assign rd_en       = access_ok && (&btb_if.btb_data_wen);

  // vld_q keeps the clock alive one extra edge so the read strobe always drops.
  gated_clk_cell u_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_ifu_icg_en),
    .local_en           (btb_if.btb_data_clk_en | init_busy | vld_q),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (gated_clk)
  );

  always_ff @(posedge gated_clk) begin
    for (int k = 0; k < NW; k++) begin
      if (init_busy)
        mem_q[k][cnt_q[AW-1:0]] <= '0;
      else if (wr_en && !btb_if.btb_data_wen[k])
        mem_q[k][btb_if.btb_index] <= btb_if.btb_data_din[(k % SUB_NUM)*SUB_WIDTH +: SUB_WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NW; k++)
      rd_data[k*SUB_WIDTH +: SUB_WIDTH] = mem_q[k][btb_if.btb_index];
  end

  assign dout_d = rd_en ? rd_data : dout_q;
  assign vld_d  = rd_en;

  always_ff @(posedge gated_clk) begin
    if (!cpurst_b) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign btb_if.btb_data_dout      = dout_q;
  assign btb_if.btb_data_dout_vld  = vld_q;
  assign btb_if.btb_data_init_busy = init_busy;
endmodule
